mips_mc_controller: RTL and testbench
=====================================

Name: mips_mc_controller

Overview:
Multicycle control FSM for the MIPS core variant that uses one shared instruction/data memory port. It sequences the datapath through fetch, decode, execute, memory and writeback steps. It produces per-cycle enables and mux selects, and an aluop that feeds the existing ALU decoder unchanged. It supports the same ISA subset as the single-cycle core: R-type, LW, LH, SW, BEQ, ADDI, ADDIU, ORI, ANDI, LUI, J. A bounded wait on the memory handshake latches a bus error.

Parameters:
WAIT_LIMIT, 16, maximum cycles a memory request may wait for mem_ready before bus_error is raised (range 1..255).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
op  in  6  opcode from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current request this cycle
mem_req  out  1  memory request valid
memwrite  out  1  request is a write (only meaningful with mem_req)
iord  out  1  address select: 0 = PC, 1 = ALUOut register
irwrite  out  1  load instruction register
pcen  out  1  PC register enable (pcwrite | branch&zero)
pcsrc  out  2  00 ALU result, 01 ALUOut register, 10 jump target
alusrca  out  1  0 = PC, 1 = register A
alusrcb  out  2  00 register B, 01 constant 4, 10 extended imm, 11 extended imm<<2
aluop  out  3  000 add, 001 sub, 010 or, 101 and, 011 R-type (funct)
signext  out  1  immediate/halfword sign-extend enable
shiftl16  out  1  immediate <<16 (LUI)
enlh  out  1  load-halfword path select
regdst  out  1  0 = rt, 1 = rd
memtoreg  out  1  writeback from memory data register
regwrite  out  1  register file write enable
illegal  out  1  sticky, unsupported opcode decoded
bus_error  out  1  sticky, memory wait exceeded WAIT_LIMIT
state  out  4  current state, debug only

Behaviour:
- Reset (reset=0, async): state=FETCH, wait counter=0, illegal=0, bus_error=0. Every output is driven by the state decode, so outputs show their FETCH values during reset. Release of reset is sampled synchronously; the first fetch is issued on the first clk edge after release.
- All outputs are combinational decodes of state (Moore), except pcen, which includes branch&zero. Unlisted outputs are 0 in every state.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00.
  - irwrite and pcwrite are 1 only in the cycle mem_ready=1; the FSM moves to DECODE in that same cycle.
  - While mem_ready=0, the FSM holds and increments the wait counter.
- DECODE: alusrca=0, alusrcb=11, aluop=000 (branch target into ALUOut). Next state by op:
  - 100011/100001/101011 -> MEMADR
  - 000000 -> RTEXEC
  - 000100 -> BEQEX
  - 001000/001001/001101/001100/001111 -> IEXEC
  - 000010 -> JEX
  - any other op -> HALT with illegal=1
- MEMADR: alusrca=1, alusrcb=10, signext=1, aluop=000. Next is MEMRD for loads, MEMWR for SW.
- MEMRD: mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: regwrite=1, memtoreg=1, regdst=0. enlh=1 and signext=1 when op=100001. Next is FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Holds until mem_ready, then goes to FETCH.
- RTEXEC: alusrca=1, alusrcb=00, aluop=011. Next is ALUWB with regdst=1.
- IEXEC: alusrca=1, alusrcb=10.
  - ADDI/ADDIU: signext=1, aluop=000.
  - ORI: aluop=010.
  - ANDI: aluop=101.
  - LUI: shiftl16=1, aluop=000.
  - Next is ALUWB with regdst=0.
- ALUWB: regwrite=1, memtoreg=0, regdst held per source path. Next is FETCH.
- BEQEX: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, branch=1 (pcen=zero). Next is FETCH.
- JEX: pcsrc=10, pcwrite=1. Next is FETCH.
- HALT: all enables 0, mem_req=0. Left only by reset.
- Cycle counts with zero-wait memory: LW/LH 5, SW 4, R-type 4, I-type 4, BEQ 3, J 3. Each wait cycle adds 1.
- Wait counter:
  - Cleared on every state change.
  - Counts cycles with mem_req=1 and mem_ready=0.
  - On reaching WAIT_LIMIT: bus_error=1, next state HALT, no irwrite/pcwrite/regwrite issued.
- mem_ready while mem_req=0 is ignored.
- mem_ready in the same cycle the counter reaches WAIT_LIMIT: the transfer completes, no error.

Decomposition:
- Package mips_mc_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXEC, IEXEC, ALUWB, BEQEX, JEX, HALT)
  - opcode constants
  - aluop, alusrcb and pcsrc encodings
- One sub-module, mips_mc_waitcnt: 8-bit saturating counter with clear, enable and limit-reached output.

Test Plan:
- R-type with mem_ready tied 1, op=000000 -> states FETCH,DECODE,RTEXEC,ALUWB,FETCH. Single regwrite in cycle 4 with regdst=1, aluop=011.
- LH, op=100001, mem_ready low 3 cycles in MEMRD -> 8 cycles total. MEMWB has enlh=1, signext=1, memtoreg=1.
- BEQ: zero=1 -> pcen=1 in BEQEX. zero=0 -> pcen=0. In both cases the next state is FETCH after 3 cycles.
- LUI, op=001111 -> IEXEC has shiftl16=1, alusrcb=10. ALUWB has regdst=0.
- Illegal op=111111 -> HALT, illegal=1, no further mem_req. reset=0 pulse returns to FETCH with flags cleared.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH -> bus_error=1 after 4 wait cycles, HALT. Also assert reset mid-MEMWR -> immediate FETCH, memwrite=0.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared states, opcodes and select encodings for the multicycle controller
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        RTEXEC, IEXEC, ALUWB, BEQEX, JEX, HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_OR    = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b101;
    localparam logic [2:0] ALU_RTYPE = 3'b011;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Step taken out of DECODE; anything unsupported parks the core in HALT
    function automatic state_t decode_op(input logic [5:0] opc);
        case (opc)
            OP_LW, OP_LH, OP_SW:                         return MEMADR;
            OP_RTYPE:                                    return RTEXEC;
            OP_BEQ:                                      return BEQEX;
            OP_ADDI, OP_ADDIU, OP_ORI, OP_ANDI, OP_LUI:  return IEXEC;
            OP_J:                                        return JEX;
            default:                                     return HALT;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_waitcnt.sv
// mips_mc_waitcnt: saturating count of memory wait cycles with limit flag
module mips_mc_waitcnt #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic limit
);

    logic [7:0] cnt;

    // Count stalled cycles, saturating so a long stall can never wrap back to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != 8'hff)
            cnt <= cnt + 8'd1;
    end

    // High when one more stalled cycle would make WAIT_LIMIT waits
    assign limit = cnt >= 8'(WAIT_LIMIT - 1);

endmodule

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle control FSM for the shared-memory-port MIPS core
module mips_mc_controller
    import mips_mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic       signext,
    output logic       shiftl16,
    output logic       enlh,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] state
);

    state_t cur, nxt;
    logic   pcwrite, branch, limit, timeout, cnt_clr, cnt_en;

    assign cnt_en  = mem_req && !mem_ready;
    assign cnt_clr = nxt != cur;
    assign timeout = cnt_en && limit;

    mips_mc_waitcnt #(.WAIT_LIMIT(WAIT_LIMIT)) u_waitcnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (limit)
    );

    // Next step; a stalled request that hits the wait limit abandons to HALT
    always_comb begin
        nxt = cur;
        case (cur)
            FETCH:                     nxt = mem_ready ? DECODE : FETCH;
            DECODE:                    nxt = decode_op(op);
            MEMADR:                    nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:                     nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:                     nxt = mem_ready ? FETCH : MEMWR;
            RTEXEC, IEXEC:             nxt = ALUWB;
            MEMWB, ALUWB, BEQEX, JEX:  nxt = FETCH;
            default:                   nxt = HALT;
        endcase
        if (timeout)
            nxt = HALT;
    end

    // Moore decode of the current step; FETCH writes IR/PC only when the read returns
    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        pcsrc    = PC_ALU;
        alusrca  = 1'b0;
        alusrcb  = SRCB_B;
        aluop    = ALU_ADD;
        signext  = 1'b0;
        shiftl16 = 1'b0;
        enlh     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        case (cur)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = SRCB_4;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: alusrcb = SRCB_IMMSH;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                signext = 1'b1;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                enlh     = op == OP_LH;
                signext  = op == OP_LH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            RTEXEC: begin
                alusrca = 1'b1;
                aluop   = ALU_RTYPE;
            end
            IEXEC: begin
                alusrca  = 1'b1;
                alusrcb  = SRCB_IMM;
                signext  = op == OP_ADDI || op == OP_ADDIU;
                shiftl16 = op == OP_LUI;
                aluop    = op == OP_ORI ? ALU_OR : op == OP_ANDI ? ALU_AND : ALU_ADD;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = op == OP_RTYPE;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALU_SUB;
                pcsrc   = PC_ALUOUT;
                branch  = 1'b1;
            end
            JEX: begin
                pcsrc   = PC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    assign pcen  = pcwrite | (branch & zero);
    assign state = cur;

    // State register plus sticky fault flags; only reset clears them
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= FETCH;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == DECODE && nxt == HALT)
                illegal <= 1'b1;
            if (timeout)
                bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_mc_controller.sv
// tb_mips_mc_controller: directed scoreboard bench for the multicycle controller
module tb_mips_mc_controller;
    import mips_mc_pkg::*;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } exp_t;

    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, pcen, alusrca;
    logic       signext, shiftl16, enlh, regdst, memtoreg, regwrite, illegal, bus_error;
    logic [1:0] pcsrc, alusrcb;
    logic [2:0] aluop;
    logic [3:0] state;
    logic [24:0] obs;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    mips_mc_controller #(.WAIT_LIMIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .memwrite  (memwrite),
        .iord      (iord),
        .irwrite   (irwrite),
        .pcen      (pcen),
        .pcsrc     (pcsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .signext   (signext),
        .shiftl16  (shiftl16),
        .enlh      (enlh),
        .regdst    (regdst),
        .memtoreg  (memtoreg),
        .regwrite  (regwrite),
        .illegal   (illegal),
        .bus_error (bus_error),
        .state     (state)
    );

    always #5 clk = ~clk;

    assign obs = {state, mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
                  aluop, signext, shiftl16, enlh, regdst, memtoreg, regwrite, illegal, bus_error};

    function automatic logic [24:0] mk(input logic [3:0] st, input logic mr, mw, io, ir, pe,
                                       input logic [1:0] ps, input logic aa, input logic [1:0] ab,
                                       input logic [2:0] ao, input logic se, sl, eh, rd, mt, rw, il, be);
        return {st, mr, mw, io, ir, pe, ps, aa, ab, ao, se, sl, eh, rd, mt, rw, il, be};
    endfunction

    function automatic logic [24:0] fe(input logic r, il, be);
        return mk(FETCH, H, L, L, r, r, 2'b00, L, 2'b01, 3'b000, L, L, L, L, L, L, il, be);
    endfunction
    function automatic logic [24:0] de();
        return mk(DECODE, L, L, L, L, L, 2'b00, L, 2'b11, 3'b000, L, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] ma();
        return mk(MEMADR, L, L, L, L, L, 2'b00, H, 2'b10, 3'b000, H, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] mrd();
        return mk(MEMRD, H, L, H, L, L, 2'b00, L, 2'b00, 3'b000, L, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] mwb_lh();
        return mk(MEMWB, L, L, L, L, L, 2'b00, L, 2'b00, 3'b000, H, L, H, L, H, H, L, L);
    endfunction
    function automatic logic [24:0] mwr();
        return mk(MEMWR, H, H, H, L, L, 2'b00, L, 2'b00, 3'b000, L, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] rte();
        return mk(RTEXEC, L, L, L, L, L, 2'b00, H, 2'b00, 3'b011, L, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] iex_lui();
        return mk(IEXEC, L, L, L, L, L, 2'b00, H, 2'b10, 3'b000, L, H, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] awb(input logic rd);
        return mk(ALUWB, L, L, L, L, L, 2'b00, L, 2'b00, 3'b000, L, L, L, rd, L, H, L, L);
    endfunction
    function automatic logic [24:0] beq(input logic z);
        return mk(BEQEX, L, L, L, L, z, 2'b01, H, 2'b00, 3'b001, L, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] jx();
        return mk(JEX, L, L, L, L, H, 2'b10, L, 2'b00, 3'b000, L, L, L, L, L, L, L, L);
    endfunction
    function automatic logic [24:0] hlt(input logic il, be);
        return mk(HALT, L, L, L, L, L, 2'b00, L, 2'b00, 3'b000, L, L, L, L, L, L, il, be);
    endfunction

    task automatic expect_out(input string tag, input logic [24:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, check mid-cycle
    task automatic step(input string tag, input logic rdy, input logic z, input logic [24:0] v);
        mem_ready = rdy;
        zero = z;
        expect_out(tag, v);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse straddling one edge; FETCH must show at once
    task automatic pulse_reset(input string tag);
        mem_ready = 1'b0;
        reset = 1'b0;
        #1;
        expect_out(tag, fe(L, L, L));
        compare();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", L, L, fe(L, L, L));
        reset = 1'b1;

        op = OP_RTYPE;
        step("r_fetch", H, L, fe(H, L, L));
        step("r_decode", H, H, de());
        step("r_exec", H, H, rte());
        step("r_wb", H, H, awb(H));

        op = OP_LH;
        step("lh_fetch", H, L, fe(H, L, L));
        step("lh_decode", L, L, de());
        step("lh_memadr", H, L, ma());
        for (int i = 0; i < 3; i++) step("lh_rd_wait", L, L, mrd());
        step("lh_rd_done", H, L, mrd());
        step("lh_wb", L, L, mwb_lh());

        op = OP_LUI;
        step("lui_fetch", H, L, fe(H, L, L));
        step("lui_decode", L, L, de());
        step("lui_exec", L, L, iex_lui());
        step("lui_wb", L, L, awb(L));

        op = OP_BEQ;
        step("beq1_fetch", H, L, fe(H, L, L));
        step("beq1_decode", L, H, de());
        step("beq1_taken", L, H, beq(H));
        step("beq0_fetch", H, L, fe(H, L, L));
        step("beq0_decode", L, L, de());
        step("beq0_not_taken", L, L, beq(L));

        op = OP_J;
        step("j_fetch", H, L, fe(H, L, L));
        step("j_decode", L, L, de());
        step("j_exec", L, L, jx());

        op = OP_SW;
        for (int i = 0; i < 3; i++) step("sw_fetch_wait", L, L, fe(L, L, L));
        step("sw_fetch_ready_at_limit", H, L, fe(H, L, L));
        step("sw_decode", L, L, de());
        step("sw_memadr", L, L, ma());
        step("sw_wr_wait", L, L, mwr());
        pulse_reset("sw_reset_mid_memwr");

        for (int i = 0; i < 4; i++) step("to_fetch_wait", L, L, fe(L, L, L));
        step("to_halt", H, L, hlt(L, H));
        step("to_halt_hold", H, L, hlt(L, H));
        pulse_reset("to_reset_clears");

        op = 6'b111111;
        step("ill_fetch", H, L, fe(H, L, L));
        step("ill_decode", H, L, de());
        step("ill_halt", H, L, hlt(H, L));
        step("ill_halt_hold", H, L, hlt(H, L));
        pulse_reset("ill_reset_clears");

        op = OP_RTYPE;
        step("post_reset_fetch", H, L, fe(H, L, L));
        step("post_reset_decode", L, L, de());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
